ptp_ts_arb: RTL and testbench

- Timestamp-capture scheduler for the PTP parsers.
- Accepts per-frame results from the RX and TX PTP frame parsers: message type, sequence ID, source port identity and the 80-bit capture timestamp.
- Filters the results, arbitrates both sources round-robin into one shared timestamp FIFO, and presents a first-word-fall-through pop interface to the host register block. Overflows are counted.

---
 rtl/ptp_ts_arb.sv | 114 +++++++++++
 tb/tb_ptp_ts_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ptp_ts_arb.sv
// PTP timestamp-capture scheduler: filters RX/TX parser results into per-source hold
// registers, arbitrates them round-robin into a shared FWFT FIFO, and counts dropped events.
module ptp_ts_arb #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [3:0]    rx_msg_type,
  input  logic [15:0]   rx_seq_id,
  input  logic [79:0]   rx_src_port,
  input  logic [79:0]   rx_ts,
  input  logic          tx_valid,
  input  logic [3:0]    tx_msg_type,
  input  logic [15:0]   tx_seq_id,
  input  logic [79:0]   tx_src_port,
  input  logic [79:0]   tx_ts,
  input  logic          rx_en,
  input  logic          tx_en,
  input  logic [15:0]   type_mask,
  input  logic          ts_pop,
  input  logic          ovf_clr,
  output logic          ts_avail,
  output logic          ts_dir,
  output logic [3:0]    ts_msg_type,
  output logic [15:0]   ts_seq_id,
  output logic [79:0]   ts_src_port,
  output logic [79:0]   ts_value,
  output logic [AW:0]   ts_count,
  output logic [7:0]    ovf_cnt
);

  localparam int PW = 180;
  localparam int EW = PW + 1;

  logic          r_rx_vld_p1, r_tx_vld_p1;
  logic [PW-1:0] r_rx_pl_p1, r_tx_pl_p1;
  logic          r_last_gnt;
  logic [EW-1:0] r_mem_p2 [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_ovf;

  logic w_rx_acc, w_tx_acc, w_gnt_rx, w_gnt_tx, w_gnt, w_full, w_pop, w_wr, w_gdrop;
  logic w_rx_load, w_tx_load, w_rx_hdrop, w_tx_hdrop;
  logic [1:0]    w_ndrop;
  logic [8:0]    w_ovf_sum;
  logic [EW-1:0] w_head;

  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, base} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_rx_acc = rx_valid & rx_en & type_mask[rx_msg_type];
  assign w_tx_acc = tx_valid & tx_en & type_mask[tx_msg_type];

  // On contention the source that did not win last time is granted (last_grant 1 = TX).
  assign w_gnt_rx = r_rx_vld_p1 & (~r_tx_vld_p1 | r_last_gnt);
  assign w_gnt_tx = r_tx_vld_p1 & ~w_gnt_rx;
  assign w_gnt    = w_gnt_rx | w_gnt_tx;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop    = ts_pop & (r_count != '0);
  assign w_wr     = w_gnt & (~w_full | ts_pop);
  assign w_gdrop  = w_gnt & w_full & ~ts_pop;

  // A granted hold frees up in the same edge, so back-to-back events never collide.
  assign w_rx_load  = w_rx_acc & (~r_rx_vld_p1 | w_gnt_rx);
  assign w_tx_load  = w_tx_acc & (~r_tx_vld_p1 | w_gnt_tx);
  assign w_rx_hdrop = w_rx_acc & r_rx_vld_p1 & ~w_gnt_rx;
  assign w_tx_hdrop = w_tx_acc & r_tx_vld_p1 & ~w_gnt_tx;
  assign w_ndrop    = 2'(w_rx_hdrop) + 2'(w_tx_hdrop) + 2'(w_gdrop);
  assign w_ovf_sum  = {1'b0, sat_add8(ovf_clr ? 8'd0 : r_ovf, w_ndrop)};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_vld_p1 <= 1'b0;
      r_tx_vld_p1 <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= '0;
    end else begin
      if (w_rx_load)     r_rx_vld_p1 <= 1'b1;
      else if (w_gnt_rx) r_rx_vld_p1 <= 1'b0;
      if (w_tx_load)     r_tx_vld_p1 <= 1'b1;
      else if (w_gnt_tx) r_tx_vld_p1 <= 1'b0;
      if (w_gnt) r_last_gnt <= w_gnt_tx;
      if (w_wr)  r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_wr & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_wr & w_pop) r_count <= r_count - 1'b1;
      r_ovf <= w_ovf_sum[7:0];
    end
  end

  // Stage 1 -> stage 2 payload: hold registers and FIFO storage carry data only.
  always_ff @(posedge clk) begin
    if (w_rx_load) r_rx_pl_p1 <= {rx_msg_type, rx_seq_id, rx_src_port, rx_ts};
    if (w_tx_load) r_tx_pl_p1 <= {tx_msg_type, tx_seq_id, tx_src_port, tx_ts};
    if (w_wr)      r_mem_p2[r_wr_ptr] <= w_gnt_tx ? {1'b1, r_tx_pl_p1} : {1'b0, r_rx_pl_p1};
  end

  assign ts_avail = (r_count != '0);
  assign w_head   = ts_avail ? r_mem_p2[r_rd_ptr] : '0;
  assign {ts_dir, ts_msg_type, ts_seq_id, ts_src_port, ts_value} = w_head;
  assign ts_count = r_count;
  assign ovf_cnt  = r_ovf;

endmodule

// File: tb/tb_ptp_ts_arb.sv
// Directed bench for ptp_ts_arb: hand-computed expectations for capture, arbitration,
// filtering, FIFO full/pop corners, overflow saturation and mid-run reset.
module tb_ptp_ts_arb;
  logic        clk = 0;
  logic        rstn = 0;
  logic        rx_valid = 0, tx_valid = 0;
  logic [3:0]  rx_msg_type = 0, tx_msg_type = 0;
  logic [15:0] rx_seq_id = 0, tx_seq_id = 0;
  logic [79:0] rx_src_port = 0, tx_src_port = 0, rx_ts = 0, tx_ts = 0;
  logic        rx_en = 0, tx_en = 0;
  logic [15:0] type_mask = 0;
  logic        ts_pop = 0, ovf_clr = 0;
  logic        ts_avail, ts_dir;
  logic [3:0]  ts_msg_type;
  logic [15:0] ts_seq_id;
  logic [79:0] ts_src_port, ts_value;
  logic [2:0]  ts_count;
  logic [7:0]  ovf_cnt;

  int n_chk = 0;
  int n_pass = 0;

  ptp_ts_arb #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_msg_type(rx_msg_type), .rx_seq_id(rx_seq_id),
    .rx_src_port(rx_src_port), .rx_ts(rx_ts),
    .tx_valid(tx_valid), .tx_msg_type(tx_msg_type), .tx_seq_id(tx_seq_id),
    .tx_src_port(tx_src_port), .tx_ts(tx_ts),
    .rx_en(rx_en), .tx_en(tx_en), .type_mask(type_mask),
    .ts_pop(ts_pop), .ovf_clr(ovf_clr),
    .ts_avail(ts_avail), .ts_dir(ts_dir), .ts_msg_type(ts_msg_type),
    .ts_seq_id(ts_seq_id), .ts_src_port(ts_src_port), .ts_value(ts_value),
    .ts_count(ts_count), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rstn = 0; tick(); tick(); rstn = 1;
  endtask

  task automatic send_rx(input logic [3:0] t, input logic [15:0] s, input logic [79:0] ts);
    rx_valid = 1; rx_msg_type = t; rx_seq_id = s; rx_ts = ts; rx_src_port = 80'hAA;
    tick();
    rx_valid = 0;
  endtask

  task automatic send_pair(input logic [15:0] s_rx, input logic [15:0] s_tx);
    rx_valid = 1; rx_msg_type = 0; rx_seq_id = s_rx; rx_ts = 80'h10;
    tx_valid = 1; tx_msg_type = 1; tx_seq_id = s_tx; tx_ts = 80'h20; tx_src_port = 80'hBB;
    tick();
    rx_valid = 0; tx_valid = 0;
  endtask

  task automatic pop();
    ts_pop = 1; tick(); ts_pop = 0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_avail", ts_avail, 0);
    check_eq("rst_count", ts_count, 0);
    check_eq("rst_ovf", ovf_cnt, 0);
    check_eq("rst_seq", ts_seq_id, 0);
    check_eq("rst_ts", ts_value, 0);

    // single RX event
    type_mask = 16'h000F; rx_en = 1; tx_en = 1;
    send_rx(4'd0, 16'h1234, 80'h01);
    check_eq("t1_avail_edgeN", ts_avail, 0);
    tick();
    check_eq("t1_avail", ts_avail, 1);
    check_eq("t1_dir", ts_dir, 0);
    check_eq("t1_type", ts_msg_type, 0);
    check_eq("t1_seq", ts_seq_id, 16'h1234);
    check_eq("t1_ts", ts_value, 80'h01);
    check_eq("t1_count", ts_count, 1);
    pop();
    check_eq("t1_avail_pop", ts_avail, 0);
    check_eq("t1_count_pop", ts_count, 0);

    // contention: first conflict after reset goes to RX
    do_reset();
    send_pair(16'hA1, 16'hB1);
    idle(2);
    check_eq("t2_count", ts_count, 2);
    check_eq("t2_dir0", ts_dir, 0);
    check_eq("t2_seq0", ts_seq_id, 16'hA1);
    pop();
    check_eq("t2_dir1", ts_dir, 1);
    check_eq("t2_seq1", ts_seq_id, 16'hB1);
    check_eq("t2_type1", ts_msg_type, 1);
    pop();
    // lone RX grant makes RX the last winner, so the next conflict goes to TX
    send_rx(4'd0, 16'hC1, 80'h3);
    tick();
    check_eq("t2_lone", ts_seq_id, 16'hC1);
    pop();
    send_pair(16'hA2, 16'hB2);
    idle(2);
    check_eq("t2_rr_dir0", ts_dir, 1);
    check_eq("t2_rr_seq0", ts_seq_id, 16'hB2);
    pop();
    check_eq("t2_rr_dir1", ts_dir, 0);
    check_eq("t2_rr_seq1", ts_seq_id, 16'hA2);
    pop();
    check_eq("t2_empty", ts_count, 0);

    // filtering
    type_mask = 16'h0001;
    send_rx(4'd9, 16'h0009, 80'h9);
    idle(3);
    check_eq("t3_mask_count", ts_count, 0);
    check_eq("t3_mask_ovf", ovf_cnt, 0);
    tx_en = 0;
    tx_valid = 1; tx_msg_type = 0; tx_seq_id = 16'h0077; tick(); tx_valid = 0;
    idle(3);
    check_eq("t3_txen_count", ts_count, 0);
    tx_en = 1; type_mask = 16'h000F;

    // fill with DEPTH+2 events, no pops
    for (int k = 0; k < 6; k++) begin
      send_rx(4'd0, 16'(16'd10 + 16'(k)), 80'(k));
      tick();
    end
    check_eq("t4_count", ts_count, 4);
    check_eq("t4_ovf", ovf_cnt, 2);
    for (int k = 0; k < 4; k++) begin
      check_eq("t4_order", ts_seq_id, 16'(16'd10 + 16'(k)));
      pop();
    end
    check_eq("t4_empty", ts_count, 0);

    // full FIFO with coincident write and pop
    for (int k = 0; k < 4; k++) begin
      send_rx(4'd0, 16'(16'd20 + 16'(k)), 80'(k));
      tick();
    end
    check_eq("t5_full", ts_count, 4);
    send_rx(4'd0, 16'd24, 80'h24);
    ts_pop = 1; tick(); ts_pop = 0;
    check_eq("t5_count_wp", ts_count, 4);
    check_eq("t5_ovf_wp", ovf_cnt, 2);
    check_eq("t5_head", ts_seq_id, 16'd21);
    pop(); pop(); pop();
    check_eq("t5_last", ts_seq_id, 16'd24);
    pop();
    check_eq("t5_empty", ts_count, 0);
    pop();
    check_eq("t5_pop_empty_cnt", ts_count, 0);
    check_eq("t5_pop_empty_av", ts_avail, 0);

    // overflow saturation: FIFO full, one RX event per cycle is dropped each cycle
    for (int k = 0; k < 4; k++) begin
      send_rx(4'd0, 16'(16'd30 + 16'(k)), 80'(k));
      tick();
    end
    rx_valid = 1; rx_msg_type = 0; rx_seq_id = 16'h99;
    idle(300);
    check_eq("t6_sat", ovf_cnt, 255);
    tick();
    check_eq("t6_sat_more", ovf_cnt, 255);
    check_eq("t6_count", ts_count, 4);
    ovf_clr = 1; tick(); ovf_clr = 0;
    check_eq("t6_clr_drop", ovf_cnt, 1);

    // reset in the middle of the burst
    rstn = 0; rx_valid = 0; tick();
    check_eq("t7_avail", ts_avail, 0);
    check_eq("t7_count", ts_count, 0);
    check_eq("t7_ovf", ovf_cnt, 0);
    rstn = 1;
    idle(3);
    check_eq("t7_hold_flushed", ts_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
